event_capture: RTL and testbench

Trigger-qualified capture buffer sitting directly downstream of the trigger unit in the event monitor. It continuously records probe samples into a circular flop array once armed, and freezes a window of `pre_count` samples before and `post_count` samples after the first `trigger_hit`. The window is then streamed out over a valid/ready read port for the host/readout logic.

---
 rtl/event_capture_if.sv | 13 +
 rtl/event_capture.sv | 179 +++++++++++++++++
 tb/tb_event_capture.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/event_capture_if.sv
// Readout port of the event capture buffer: valid/ready word stream with an
// end-of-window marker. master = capture buffer, slave = host/readout logic.
interface event_capture_if #(
   parameter int PROBE_W = 32
);
   logic [PROBE_W-1:0] rd_data;
   logic               rd_valid;
   logic               rd_ready;
   logic               rd_last;

   modport master (output rd_data, rd_valid, rd_last, input rd_ready);
   modport slave  (input rd_data, rd_valid, rd_last, output rd_ready);
endinterface

// File: rtl/event_capture.sv
// Trigger-qualified capture buffer. Once armed it records the delayed probe
// bus into a circular flop array, freezes pre_count samples before and
// post_count samples after the first accepted trigger, then streams that
// window out over the rd valid/ready port.
// Optional feature: define EVENT_CAPTURE_TIMESTAMP_EN to add a free-running
// cycle counter and the trig_ts output holding the trigger sample's cycle.
module event_capture #(
   parameter int  PROBE_W = 32,
   parameter int  DEPTH   = 64,
   localparam int CNT_W   = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               arm,
   input  logic               abort,
   input  logic [CNT_W-1:0]   pre_count,
   input  logic [CNT_W-1:0]   post_count,
   input  logic [PROBE_W-1:0] probe_data,
   input  logic               trigger_hit,
   event_capture_if.master    rd,
   output logic               busy,
   output logic               armed,
   output logic               triggered
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
   ,
   output logic [31:0]        trig_ts
`endif
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_PRE   = 3'd1;
   localparam logic [2:0] S_ARMED = 3'd2;
   localparam logic [2:0] S_POST  = 3'd3;
   localparam logic [2:0] S_READ  = 3'd4;

   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

   logic [2:0]         state_reg;
   logic [PROBE_W-1:0] probe_d_reg;
   logic [PROBE_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0]   wp_reg;
   logic [CNT_W-1:0]   rp_reg;
   logic [CNT_W-1:0]   tp_reg;
   logic [CNT_W-1:0]   pre_l_reg;
   logic [CNT_W-1:0]   post_l_reg;
   logic [CNT_W-1:0]   remain_reg;
   logic [CNT_W:0]     fill_reg;
   logic [CNT_W:0]     rlen_reg;
   logic               triggered_reg;

   logic [CNT_W-1:0]   post_room;
   logic [CNT_W-1:0]   post_clamped;
   logic [CNT_W:0]     fill_next;
   logic [CNT_W:0]     rlen_init;
   logic               wr_en;
   logic               trig_acc;

   // The post window is clamped so pre + 1 + post never exceeds DEPTH.
   assign post_room    = {CNT_W{1'b1}} - pre_count;
   assign post_clamped = (post_count > post_room) ? post_room : post_count;
   assign fill_next    = (fill_reg == DEPTH_C) ? fill_reg : fill_reg + 1'b1;
   assign rlen_init    = {1'b0, pre_l_reg} + {1'b0, post_l_reg} + 1'b1;
   assign wr_en        = !rst && !abort &&
                         (state_reg == S_PRE || state_reg == S_ARMED || state_reg == S_POST);
   assign trig_acc     = !rst && !abort && (state_reg == S_ARMED) && trigger_hit;

   // Delay the probe by one cycle so it lines up with the registered trigger.
   always_ff @(posedge clk) begin
      probe_d_reg <= probe_data;
   end

   // Capture memory: plain flop array, no reset, written while recording.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wp_reg] <= probe_d_reg;
      end
   end

   // Capture/readout sequencer; abort overrides arm and trigger.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= S_IDLE;
         wp_reg        <= '0;
         rp_reg        <= '0;
         tp_reg        <= '0;
         fill_reg      <= '0;
         remain_reg    <= '0;
         rlen_reg      <= '0;
         pre_l_reg     <= '0;
         post_l_reg    <= '0;
         triggered_reg <= 1'b0;
      end else if (abort) begin
         state_reg     <= S_IDLE;
         triggered_reg <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (arm) begin
                  wp_reg     <= '0;
                  fill_reg   <= '0;
                  pre_l_reg  <= pre_count;
                  post_l_reg <= post_clamped;
                  state_reg  <= (pre_count == '0) ? S_ARMED : S_PRE;
               end
            end
            S_PRE: begin
               // Triggers are ignored until the full pre-history is present.
               wp_reg   <= wp_reg + 1'b1;
               fill_reg <= fill_next;
               if (fill_next == {1'b0, pre_l_reg}) begin
                  state_reg <= S_ARMED;
               end
            end
            S_ARMED: begin
               wp_reg <= wp_reg + 1'b1;
               if (trigger_hit) begin
                  tp_reg        <= wp_reg;
                  remain_reg    <= post_l_reg;
                  triggered_reg <= 1'b1;
                  rlen_reg      <= rlen_init;
                  rp_reg        <= wp_reg - pre_l_reg;
                  state_reg     <= (post_l_reg != '0) ? S_POST : S_READ;
               end
            end
            S_POST: begin
               wp_reg     <= wp_reg + 1'b1;
               remain_reg <= remain_reg - 1'b1;
               rp_reg     <= tp_reg - pre_l_reg;
               if (remain_reg == 1) begin
                  state_reg <= S_READ;
               end
            end
            S_READ: begin
               if (rd.rd_ready) begin
                  rp_reg   <= rp_reg + 1'b1;
                  rlen_reg <= rlen_reg - 1'b1;
                  if (rlen_reg == 1) begin
                     state_reg     <= S_IDLE;
                     triggered_reg <= 1'b0;
                  end
               end
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   // Readout is a combinational read of the frozen flop array.
   assign rd.rd_data  = mem[rp_reg];
   assign rd.rd_valid = (state_reg == S_READ);
   assign rd.rd_last  = (state_reg == S_READ) && (rlen_reg == 1);
   assign busy        = (state_reg != S_IDLE);
   assign armed       = (state_reg == S_ARMED);
   assign triggered   = triggered_reg;

`ifdef EVENT_CAPTURE_TIMESTAMP_EN
   logic [31:0] ts_cnt_reg;
   logic [31:0] trig_ts_reg;

   // Free-running cycle counter; the trigger sample was taken one cycle earlier.
   always_ff @(posedge clk) begin
      if (rst) begin
         ts_cnt_reg  <= '0;
         trig_ts_reg <= '0;
      end else begin
         ts_cnt_reg <= ts_cnt_reg + 1'b1;
         if (trig_acc) begin
            trig_ts_reg <= ts_cnt_reg - 1'b1;
         end
      end
   end

   assign trig_ts = trig_ts_reg;
`else
   logic unused_trig_acc;
   assign unused_trig_acc = trig_acc;
`endif

endmodule

// File: tb/tb_event_capture.sv
// Self-checking bench for event_capture. The probe is a free-running counter,
// so every expected readout word is known when the trigger is driven; those
// words go into a scoreboard queue and are popped on each read handshake.
module tb_event_capture;
   localparam int PROBE_W = 32;
   localparam int DEPTH   = 64;
   localparam int CNT_W   = 6;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             arm = 1'b0;
   logic             abort = 1'b0;
   logic [CNT_W-1:0] pre_count = '0;
   logic [CNT_W-1:0] post_count = '0;
   logic [31:0]      probe_data = '0;
   logic             trigger_hit = 1'b0;
   logic             busy;
   logic             armed;
   logic             triggered;
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
   logic [31:0]      trig_ts;
`endif

   int          checks = 0;
   int          errors = 0;
   int          ts_model = 0;
   logic [31:0] exp_q[$];

   event_capture_if #(.PROBE_W(PROBE_W)) rd_if ();

   event_capture #(.PROBE_W(PROBE_W), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .arm         (arm),
      .abort       (abort),
      .pre_count   (pre_count),
      .post_count  (post_count),
      .probe_data  (probe_data),
      .trigger_hit (trigger_hit),
      .rd          (rd_if),
      .busy        (busy),
      .armed       (armed),
      .triggered   (triggered)
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
      ,
      .trig_ts     (trig_ts)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

   // One clock: outputs settle by #1, then the probe counter advances.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rst) ts_model = 0;
      else ts_model++;
      probe_data = probe_data + 1;
   endtask

   task automatic do_reset();
      rst = 1'b1; arm = 1'b0; abort = 1'b0; trigger_hit = 1'b0;
      rd_if.rd_ready = 1'b0;
      tick(); tick();
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic arm_cap(input int pre, input int post);
      pre_count = CNT_W'(pre); post_count = CNT_W'(post); arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   // Trigger on the probe value currently presented; push the expected window.
   task automatic fire(input int pre_l, input int post_l, input string name);
      logic [31:0] v;
      v = probe_data;
      for (int i = 0; i <= pre_l + post_l; i++) exp_q.push_back(v - 32'(pre_l) + 32'(i));
      tick();
      trigger_hit = 1'b1;
      tick();
      trigger_hit = 1'b0;
      checks++;
      if (triggered !== 1'b1) begin
         errors++; $display("FAIL %s_triggered got %b exp 1", name, triggered);
      end
      $display("trigger %s value %h pre %0d post %0d", name, v, pre_l, post_l);
   endtask

   // rd_valid must rise exactly post_l cycles after trigger acceptance.
   task automatic expect_read(input int post_l, input string name);
      for (int i = 0; i < post_l; i++) begin
         checks++;
         if (rd_if.rd_valid !== 1'b0) begin
            errors++; $display("FAIL %s_early_valid got %b exp 0 at %0d", name, rd_if.rd_valid, i);
         end
         tick();
      end
      checks++;
      if (rd_if.rd_valid !== 1'b1) begin
         errors++; $display("FAIL %s_read_latency got %b exp 1", name, rd_if.rd_valid);
      end
   endtask

   task automatic drain(input bit toggle, input string name);
      logic [31:0] held_d, e;
      logic        held_l;
      bit          stalled, done;
      stalled = 0; done = 0; held_d = '0; held_l = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         rd_if.rd_ready = toggle ? (c % 2 == 0) : 1'b1;
         if (stalled) begin
            checks++;
            if (rd_if.rd_data !== held_d || rd_if.rd_last !== held_l) begin
               errors++; $display("FAIL %s_stall got %h/%b exp %h/%b", name, rd_if.rd_data, rd_if.rd_last, held_d, held_l);
            end
         end
         stalled = 0;
         checks++;
         if (rd_if.rd_valid !== 1'b1) begin
            errors++; $display("FAIL %s_valid got %b exp 1 (%0d words left)", name, rd_if.rd_valid, exp_q.size());
            done = 1;
         end else if (rd_if.rd_ready) begin
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL %s_extra got %h exp none", name, rd_if.rd_data);
               done = 1;
            end else begin
               e = exp_q.pop_front();
               checks++;
               if (rd_if.rd_data !== e || rd_if.rd_last !== (exp_q.size() == 0)) begin
                  errors++; $display("FAIL %s_word got %h last %b exp %h last %b", name, rd_if.rd_data, rd_if.rd_last, e, exp_q.size() == 0);
               end else begin
                  $display("read %s word %h last %b", name, e, rd_if.rd_last);
               end
               if (exp_q.size() == 0) done = 1;
            end
         end else begin
            stalled = 1; held_d = rd_if.rd_data; held_l = rd_if.rd_last;
         end
         tick();
      end
      checks++;
      if (!done) begin
         errors++; $display("FAIL %s_timeout got %0d words left exp 0", name, exp_q.size());
      end
      checks++;
      if (busy !== 1'b0 || rd_if.rd_valid !== 1'b0) begin
         errors++; $display("FAIL %s_idle got busy %b valid %b exp 0 0", name, busy, rd_if.rd_valid);
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({rd_if.rd_valid, rd_if.rd_last, busy, armed, triggered} !== 5'b0) begin
         errors++; $display("FAIL reset got %b exp 00000", {rd_if.rd_valid, rd_if.rd_last, busy, armed, triggered});
      end
      $display("reset outputs %b", {rd_if.rd_valid, rd_if.rd_last, busy, armed, triggered});
   endtask

   task automatic test_basic_window();
      arm_cap(4, 3);
      checks++;
      if (busy !== 1'b1 || armed !== 1'b0) begin
         errors++; $display("FAIL basic_pre got busy %b armed %b exp 1 0", busy, armed);
      end
      repeat (4) tick();
      checks++;
      if (armed !== 1'b1) begin
         errors++; $display("FAIL basic_armed got %b exp 1", armed);
      end
      for (int i = 0; i < 100 && probe_data != 32'h20; i++) tick();
      checks++;
      if (probe_data != 32'h20) begin
         errors++; $display("FAIL basic_probe got %h exp 00000020", probe_data);
      end
      fire(4, 3, "basic");
      expect_read(3, "basic");
      drain(1'b0, "basic");
   endtask

   task automatic test_single();
      arm_cap(0, 0);
      checks++;
      if (armed !== 1'b1) begin
         errors++; $display("FAIL single_armed got %b exp 1", armed);
      end
      tick(); tick();
      fire(0, 0, "single");
      expect_read(0, "single");
      checks++;
      if (rd_if.rd_last !== 1'b1) begin
         errors++; $display("FAIL single_last got %b exp 1", rd_if.rd_last);
      end
      drain(1'b0, "single");
   endtask

   task automatic test_clamp_wrap();
      arm_cap(60, 63);
      repeat (60) tick();
      checks++;
      if (armed !== 1'b1) begin
         errors++; $display("FAIL wrap_armed got %b exp 1", armed);
      end
      repeat (200) tick();
      fire(60, 3, "wrap");
      expect_read(3, "wrap");
      drain(1'b0, "wrap");
   endtask

   task automatic test_back_to_back();
      arm_cap(8, 5);
      tick(); tick();
      trigger_hit = 1'b1;
      tick();
      trigger_hit = 1'b0;
      checks++;
      if (triggered !== 1'b0 || armed !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL early_trig got trig %b armed %b busy %b exp 0 0 1", triggered, armed, busy);
      end
      for (int i = 0; i < 20 && !armed; i++) tick();
      checks++;
      if (armed !== 1'b1) begin
         errors++; $display("FAIL bp_armed got %b exp 1", armed);
      end
      repeat (5) tick();
      fire(8, 5, "bp");
      expect_read(5, "bp");
      drain(1'b1, "bp");
   endtask

   task automatic test_abort();
      bit seen;
      arm_cap(2, 10);
      repeat (2) tick();
      fire(2, 10, "abort");
      repeat (3) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || triggered !== 1'b0) begin
         errors++; $display("FAIL abort_idle got busy %b trig %b exp 0 0", busy, triggered);
      end
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (rd_if.rd_valid !== 1'b0) seen = 1;
         tick();
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL abort_valid got 1 exp 0");
      end
      exp_q.delete();
      $display("abort done busy %b", busy);
   endtask

   task automatic test_arm_while_armed();
      arm_cap(2, 1);
      repeat (2) tick();
      pre_count = '0; post_count = '0; arm = 1'b1;
      tick();
      arm = 1'b0;
      checks++;
      if (armed !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL rearm got armed %b busy %b exp 1 1", armed, busy);
      end
      fire(2, 1, "rearm");
      expect_read(1, "rearm");
      drain(1'b0, "rearm");
   endtask

   task automatic test_reset_in_read();
      arm_cap(3, 2);
      repeat (3) tick();
      fire(3, 2, "rstrd");
      expect_read(2, "rstrd");
      rd_if.rd_ready = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({rd_if.rd_valid, rd_if.rd_last, busy, armed, triggered} !== 5'b0) begin
         errors++; $display("FAIL rst_read got %b exp 00000", {rd_if.rd_valid, rd_if.rd_last, busy, armed, triggered});
      end
      exp_q.delete();
      tick();
      $display("reset in read outputs %b", {rd_if.rd_valid, rd_if.rd_last, busy, armed, triggered});
   endtask

`ifdef EVENT_CAPTURE_TIMESTAMP_EN
   task automatic test_timestamp();
      do_reset();
      arm_cap(0, 0);
      for (int i = 0; i < 200 && ts_model != 100; i++) tick();
      fire(0, 0, "ts");
      checks++;
      if (trig_ts !== 32'd100) begin
         errors++; $display("FAIL ts got %0d exp 100", trig_ts);
      end
      expect_read(0, "ts");
      drain(1'b0, "ts");
   endtask
`endif

   initial begin
      rd_if.rd_ready = 1'b0;
      test_reset();
      test_basic_window();
      test_single();
      test_clamp_wrap();
      test_back_to_back();
      test_abort();
      test_arm_while_armed();
      test_reset_in_read();
`ifdef EVENT_CAPTURE_TIMESTAMP_EN
      test_timestamp();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
